// File: rtl/ycr_pipe_div_if.sv
// Command/result bundle between the EXU and the pipeline divider.
// Same handshake shape as the pipeline multiplier: valid in, ready pulse out, done back.
// Operands carry their sign in bit[32]; results hold until the next accepted command.
interface ycr_pipe_div_if;
  logic        data_valid;
  logic [32:0] Din1;
  logic [32:0] Din2;
  logic [31:0] des_quo;
  logic [31:0] des_rem;
  logic        div_zero_o;
  logic        div_rdy_o;
  logic        data_done;

  modport master (
    output data_valid, Din1, Din2, data_done,
    input  des_quo, des_rem, div_zero_o, div_rdy_o
  );

  modport slave (
    input  data_valid, Din1, Din2, data_done,
    output des_quo, des_rem, div_zero_o, div_rdy_o
  );
endinterface

// File: rtl/ycr_pipe_div.sv
// Iterative 32/32 signed/unsigned divider producing quotient and remainder (RISC-V DIV/DIVU/REM/REMU).
// Latency: ready pulse in the cycle after edge accept+N+2 (N = 32/BPC), 18 cycles for BPC=2.
// Backpressure: one command at a time; new commands are taken only after data_done returns it to idle.
module ycr_pipe_div #(
  parameter int BPC = 2
) (
  input  logic clk,
  input  logic rstn,
  ycr_pipe_div_if.slave bus
);

  localparam int N = 32 / BPC;
  localparam logic [4:0] LAST_CNT = 5'(N - 1);

  localparam logic [2:0] WAIT_CMD       = 3'd0;
  localparam logic [2:0] WAIT_NEG_CHECK = 3'd1;
  localparam logic [2:0] WAIT_COMP      = 3'd2;
  localparam logic [2:0] WAIT_FIX       = 3'd3;
  localparam logic [2:0] WAIT_EXIT      = 3'd4;

  logic [2:0]  state_q, state_d;
  logic [31:0] a_q, a_d;          // dividend (raw, then magnitude)
  logic [31:0] b_q, b_d;          // divisor (raw, then magnitude)
  logic        s1_q, s1_d, s2_q, s2_d, dz_q, dz_d;
  logic [31:0] quo_q, quo_d;      // dividend bits shift out of the top while quotient bits enter the bottom
  logic [31:0] rem_q, rem_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] des_quo_q, des_quo_d, des_rem_q, des_rem_d;
  logic        dzo_q, dzo_d, rdy_q;

  logic [31:0] step_quo, step_rem;
  logic [32:0] trial;

  function automatic logic [31:0] neg32(input logic [31:0] x);
    return ~x + 32'd1;
  endfunction

  // BPC restoring steps, MSB first, with a 33-bit partial remainder for the compare
  always_comb begin
    step_quo = quo_q;
    step_rem = rem_q;
    trial    = '0;
    for (int i = 0; i < BPC; i++) begin
      trial    = {step_rem, step_quo[31]};
      step_quo = {step_quo[30:0], 1'b0};
      if (trial >= {1'b0, b_q}) begin
        trial       = trial - {1'b0, b_q};
        step_quo[0] = 1'b1;
      end
      step_rem = trial[31:0];
    end
  end

  // Sequencing and next-state for operands, working registers and results
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    s1_d      = s1_q;
    s2_d      = s2_q;
    dz_d      = dz_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    cnt_d     = cnt_q;
    des_quo_d = des_quo_q;
    des_rem_d = des_rem_q;
    dzo_d     = dzo_q;
    case (state_q)
      WAIT_CMD: begin
        if (bus.data_valid) begin
          a_d     = bus.Din1[31:0];
          b_d     = bus.Din2[31:0];
          s1_d    = bus.Din1[32];
          s2_d    = bus.Din2[32];
          dz_d    = (bus.Din2[31:0] == 32'd0);
          quo_d   = '0;
          rem_d   = '0;
          state_d = WAIT_NEG_CHECK;
        end
      end
      WAIT_NEG_CHECK: begin
        a_d     = s1_q ? neg32(a_q) : a_q;
        b_d     = s2_q ? neg32(b_q) : b_q;
        quo_d   = a_d;
        cnt_d   = '0;
        state_d = WAIT_COMP;
      end
      WAIT_COMP: begin
        quo_d = step_quo;
        rem_d = step_rem;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == LAST_CNT) state_d = WAIT_FIX;
      end
      WAIT_FIX: begin
        if (dz_q) begin
          // Re-negating the magnitude restores the dividend exactly as presented
          des_quo_d = 32'hFFFF_FFFF;
          des_rem_d = s1_q ? neg32(a_q) : a_q;
        end else begin
          des_quo_d = (s1_q ^ s2_q) ? neg32(quo_q) : quo_q;
          des_rem_d = s1_q ? neg32(rem_q) : rem_q;
        end
        dzo_d   = dz_q;
        state_d = WAIT_EXIT;
      end
      WAIT_EXIT: begin
        if (bus.data_done) state_d = WAIT_CMD;
      end
      default: state_d = WAIT_CMD;
    endcase
  end

  // State registers; reset aborts any operation in flight
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= WAIT_CMD;
      a_q       <= '0;
      b_q       <= '0;
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      dz_q      <= 1'b0;
      quo_q     <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
      des_quo_q <= '0;
      des_rem_q <= '0;
      dzo_q     <= 1'b0;
      rdy_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      dz_q      <= dz_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      cnt_q     <= cnt_d;
      des_quo_q <= des_quo_d;
      des_rem_q <= des_rem_d;
      dzo_q     <= dzo_d;
      rdy_q     <= (state_q == WAIT_FIX);
    end
  end

  assign bus.des_quo    = des_quo_q;
  assign bus.des_rem    = des_rem_q;
  assign bus.div_zero_o = dzo_q;
  assign bus.div_rdy_o  = rdy_q;

endmodule

// File: tb/tb_ycr_pipe_div.sv
// Directed-vector bench for ycr_pipe_div (BPC=2): results, latency, handshake and reset abort.
module tb_ycr_pipe_div;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  ycr_pipe_div_if bus();

  ycr_pipe_div #(.BPC(2)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a command, then scramble the operand pins; returns ready latency and the ready level one cycle later
  task automatic issue(input logic [32:0] d1, input logic [32:0] d2, input bit noisy,
                       output int lat, output logic rdy_after);
    bus.Din1 = d1;
    bus.Din2 = d2;
    bus.data_valid = 1'b1;
    tick();
    bus.data_valid = 1'b0;
    bus.Din1 = 33'h1_2345_6789;
    bus.Din2 = 33'h0_0000_0003;
    lat = -1;
    for (int j = 1; j <= 60; j++) begin
      if (noisy) bus.data_valid = (j >= 2 && j <= 10);
      tick();
      if (bus.div_rdy_o === 1'b1) begin
        lat = j;
        break;
      end
    end
    bus.data_valid = 1'b0;
    tick();
    rdy_after = bus.div_rdy_o;
  endtask

  task automatic release_done();
    bus.data_done = 1'b1;
    tick();
    bus.data_done = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    bus.data_valid = 1'b0;
    bus.data_done = 1'b0;
    bus.Din1 = '0;
    bus.Din2 = '0;
    #3;
    n_checks++;
    if ({bus.des_quo, bus.des_rem, bus.div_zero_o, bus.div_rdy_o} !== 66'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got quo=%h rem=%h dz=%b rdy=%b, expected all zero",
               bus.des_quo, bus.des_rem, bus.div_zero_o, bus.div_rdy_o);
    end
    tick();
    tick();
    rstn = 1'b1;
    tick();
    n_checks++;
    if (bus.div_rdy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle_rdy: got %b expected 0", bus.div_rdy_o);
    end
  endtask

  task automatic test_unsigned();
    int lat;
    logic ra;
    issue(33'h0_0000_0064, 33'h0_0000_0007, 1'b0, lat, ra);
    n_checks++;
    if (bus.des_quo !== 32'h0000_000E) begin n_fail++; $display("FAIL unsigned_quo: got %h expected 0000000e", bus.des_quo); end
    n_checks++;
    if (bus.des_rem !== 32'h0000_0002) begin n_fail++; $display("FAIL unsigned_rem: got %h expected 00000002", bus.des_rem); end
    n_checks++;
    if (bus.div_zero_o !== 1'b0) begin n_fail++; $display("FAIL unsigned_dz: got %b expected 0", bus.div_zero_o); end
    n_checks++;
    if (lat !== 18) begin n_fail++; $display("FAIL unsigned_latency: got %0d expected 18", lat); end
    n_checks++;
    if (ra !== 1'b0) begin n_fail++; $display("FAIL unsigned_pulse_width: rdy still %b one cycle later, expected 0", ra); end
    release_done();
  endtask

  task automatic test_signed();
    int lat;
    logic ra;
    issue(33'h1_FFFF_FFF9, 33'h0_0000_0002, 1'b0, lat, ra);
    n_checks++;
    if (bus.des_quo !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL signed_neg_dvd_quo: got %h expected fffffffd", bus.des_quo); end
    n_checks++;
    if (bus.des_rem !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL signed_neg_dvd_rem: got %h expected ffffffff", bus.des_rem); end
    n_checks++;
    if (lat !== 18) begin n_fail++; $display("FAIL signed_latency: got %0d expected 18", lat); end
    release_done();
    issue(33'h0_0000_0007, 33'h1_FFFF_FFFE, 1'b0, lat, ra);
    n_checks++;
    if (bus.des_quo !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL signed_neg_dvs_quo: got %h expected fffffffd", bus.des_quo); end
    n_checks++;
    if (bus.des_rem !== 32'h0000_0001) begin n_fail++; $display("FAIL signed_neg_dvs_rem: got %h expected 00000001", bus.des_rem); end
    release_done();
  endtask

  task automatic test_div_zero();
    int lat;
    logic ra;
    issue(33'h1_FFFF_EDCC, 33'h0_0000_0000, 1'b0, lat, ra);
    n_checks++;
    if (bus.des_quo !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL divzero_quo: got %h expected ffffffff", bus.des_quo); end
    n_checks++;
    if (bus.des_rem !== 32'hFFFF_EDCC) begin n_fail++; $display("FAIL divzero_rem: got %h expected ffffedcc", bus.des_rem); end
    n_checks++;
    if (bus.div_zero_o !== 1'b1) begin n_fail++; $display("FAIL divzero_flag: got %b expected 1", bus.div_zero_o); end
    n_checks++;
    if (lat !== 18) begin n_fail++; $display("FAIL divzero_latency: got %0d expected 18", lat); end
    release_done();
  endtask

  task automatic test_overflow();
    int lat;
    logic ra;
    issue(33'h1_8000_0000, 33'h1_FFFF_FFFF, 1'b0, lat, ra);
    n_checks++;
    if (bus.des_quo !== 32'h8000_0000) begin n_fail++; $display("FAIL overflow_quo: got %h expected 80000000", bus.des_quo); end
    n_checks++;
    if (bus.des_rem !== 32'h0000_0000) begin n_fail++; $display("FAIL overflow_rem: got %h expected 00000000", bus.des_rem); end
    n_checks++;
    if (bus.div_zero_o !== 1'b0) begin n_fail++; $display("FAIL overflow_dz: got %b expected 0 after a zero-divide", bus.div_zero_o); end
    release_done();
    issue(33'h0_FFFF_FFFF, 33'h0_0000_0001, 1'b0, lat, ra);
    n_checks++;
    if (bus.des_quo !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL umax_quo: got %h expected ffffffff", bus.des_quo); end
    n_checks++;
    if (bus.des_rem !== 32'h0000_0000) begin n_fail++; $display("FAIL umax_rem: got %h expected 00000000", bus.des_rem); end
    release_done();
  endtask

  task automatic test_ignore_valid_compute();
    int lat;
    logic ra;
    // 1000 / 19 = 52 r 12, with data_valid pulsing mid-compute
    issue(33'h0_0000_03E8, 33'h0_0000_0013, 1'b1, lat, ra);
    n_checks++;
    if (bus.des_quo !== 32'h0000_0034) begin n_fail++; $display("FAIL busy_valid_quo: got %h expected 00000034", bus.des_quo); end
    n_checks++;
    if (bus.des_rem !== 32'h0000_000C) begin n_fail++; $display("FAIL busy_valid_rem: got %h expected 0000000c", bus.des_rem); end
    n_checks++;
    if (lat !== 18) begin n_fail++; $display("FAIL busy_valid_latency: got %0d expected 18", lat); end
    release_done();
  endtask

  task automatic test_handshake_hold();
    int lat;
    logic ra;
    int bad;
    int seen;
    // 100 / 7 = 14 r 2, then hold data_done low while data_valid is offered
    issue(33'h0_0000_0064, 33'h0_0000_0007, 1'b0, lat, ra);
    bad = 0;
    bus.Din1 = 33'h0_0000_0009;
    bus.Din2 = 33'h0_0000_0003;
    bus.data_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (bus.div_rdy_o !== 1'b0 || bus.des_quo !== 32'h0000_000E || bus.des_rem !== 32'h0000_0002) bad++;
    end
    n_checks++;
    if (bad !== 0) begin n_fail++; $display("FAIL hold_stable: %0d unstable cycles, expected 0 (quo=%h rem=%h)", bad, bus.des_quo, bus.des_rem); end
    // data_valid together with data_done must not start a new operation
    bus.data_done = 1'b1;
    tick();
    bus.data_done = 1'b0;
    bus.data_valid = 1'b0;
    seen = 0;
    for (int k = 0; k < 25; k++) begin
      tick();
      if (bus.div_rdy_o === 1'b1) seen++;
    end
    n_checks++;
    if (seen !== 0) begin n_fail++; $display("FAIL valid_with_done: got %0d ready pulses, expected 0", seen); end
    n_checks++;
    if (bus.des_quo !== 32'h0000_000E) begin n_fail++; $display("FAIL valid_with_done_quo: got %h expected 0000000e", bus.des_quo); end
    // Re-presenting in idle starts the operation: 9 / 3 = 3 r 0
    issue(33'h0_0000_0009, 33'h0_0000_0003, 1'b0, lat, ra);
    n_checks++;
    if (bus.des_quo !== 32'h0000_0003 || lat !== 18) begin
      n_fail++;
      $display("FAIL represent_after_done: got quo=%h lat=%0d expected quo=00000003 lat=18", bus.des_quo, lat);
    end
    release_done();
  endtask

  task automatic test_reset_midop();
    int lat;
    logic ra;
    int seen;
    bus.Din1 = 33'h0_0000_0064;
    bus.Din2 = 33'h0_0000_0007;
    bus.data_valid = 1'b1;
    tick();
    bus.data_valid = 1'b0;
    for (int j = 1; j <= 5; j++) tick();
    rstn = 1'b0;
    #2;
    n_checks++;
    if ({bus.des_quo, bus.des_rem, bus.div_zero_o, bus.div_rdy_o} !== 66'd0) begin
      n_fail++;
      $display("FAIL midop_reset_outputs: got quo=%h rem=%h dz=%b rdy=%b, expected all zero",
               bus.des_quo, bus.des_rem, bus.div_zero_o, bus.div_rdy_o);
    end
    n_checks++;
    if (dut.state_q !== 3'd0) begin n_fail++; $display("FAIL midop_reset_state: got %0d expected 0", dut.state_q); end
    tick();
    rstn = 1'b1;
    seen = 0;
    for (int k = 0; k < 25; k++) begin
      tick();
      if (bus.div_rdy_o === 1'b1) seen++;
    end
    n_checks++;
    if (seen !== 0) begin n_fail++; $display("FAIL midop_no_pulse: got %0d ready pulses, expected 0", seen); end
    issue(33'h0_0000_0064, 33'h0_0000_0007, 1'b0, lat, ra);
    n_checks++;
    if (bus.des_quo !== 32'h0000_000E || bus.des_rem !== 32'h0000_0002) begin
      n_fail++;
      $display("FAIL post_reset_result: got quo=%h rem=%h expected 0000000e 00000002", bus.des_quo, bus.des_rem);
    end
    n_checks++;
    if (lat !== 18) begin n_fail++; $display("FAIL post_reset_latency: got %0d expected 18", lat); end
    release_done();
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_overflow();
    test_ignore_valid_compute();
    test_handshake_hold();
    test_reset_midop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
